vgachargen_mem_bist: RTL and testbench

// - Self-checking write/readback sweep engine for one synchronous RAM port
//   (col_map, ch_map or ch_t) of vgachargen.
// - Writes a selectable data pattern over the address range, then reads every

---
 rtl/vgachargen_mem_bist.sv | 271 +++++++++++++++++++++++++++
 tb/tb_vgachargen_mem_bist.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vgachargen_mem_bist.sv
// ----------------------------------------------------------------------------
// vgachargen_mem_bist
// Write/readback sweep engine for one synchronous RAM port of vgachargen.
// A start in IDLE latches mode/seed, then the engine writes a pattern to
// addresses 0..DEPTH-1 and reads them all back through a RD_LATENCY-deep
// compare pipeline. It then reports pass/fail, the mismatch count and the
// first failing word.
//
// Ports
//   sys_clk_i / sys_arst_i    clock, asynchronous active-high reset
//   start_i, mode_i, seed_i   run request and pattern configuration
//   mem_addr_o / mem_data_o / mem_wen_o / mem_data_i   RAM port
//   busy_o, done_o, pass_o    run status (done_o is a one-cycle pulse)
//   err_cnt_o                 saturating mismatch count
//   err_addr_o/_exp_o/_act_o  first mismatch capture
//
// Optional feature macro: VGACHARGEN_BIST_STOP_ON_ERR_EN
//   defined   : the first mismatch ends the sweep and goes to DONE
//   undefined : the full sweep always completes, all mismatches counted
// ----------------------------------------------------------------------------
module vgachargen_mem_bist #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 2400,
   parameter int RD_LATENCY = 1
) (
   input  logic                  sys_clk_i,
   input  logic                  sys_arst_i,
   input  logic                  start_i,
   input  logic [1:0]            mode_i,
   input  logic [DATA_WIDTH-1:0] seed_i,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_data_o,
   output logic                  mem_wen_o,
   input  logic [DATA_WIDTH-1:0] mem_data_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  pass_o,
   output logic [ADDR_WIDTH:0]   err_cnt_o,
   output logic [ADDR_WIDTH-1:0] err_addr_o,
   output logic [DATA_WIDTH-1:0] err_exp_o,
   output logic [DATA_WIDTH-1:0] err_act_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WRITE = 3'd1;
   localparam logic [2:0] S_READ  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [2:0]            LAT_LAST = 3'(RD_LATENCY - 1);
   localparam logic [ADDR_WIDTH:0]   CNT_MAX  = {(ADDR_WIDTH+1){1'b1}};

`ifdef VGACHARGEN_BIST_STOP_ON_ERR_EN
   localparam logic STOP_EN = 1'b1;
`else
   localparam logic STOP_EN = 1'b0;
`endif

   // Data pattern for sweep index idx; the index is truncated/extended to the data width.
   function automatic logic [DATA_WIDTH-1:0] f_pattern(
      input logic [1:0]            mode,
      input logic [DATA_WIDTH-1:0] seed,
      input logic [ADDR_WIDTH-1:0] idx
   );
      logic [DATA_WIDTH-1:0] w_i;
      logic [DATA_WIDTH-1:0] w_p;
      logic                  w_odd;
      w_i = DATA_WIDTH'(idx);
      w_p = '0;
      case (mode)
         2'd0:    w_p = seed + w_i;
         2'd1:    w_p = ~(seed + w_i);
         2'd2:    w_p = w_i;
         default: begin
            // even index -> 0x55.., odd index -> 0xAA..
            for (int b = 0; b < DATA_WIDTH; b++) begin
               w_odd  = (b % 2) == 1;
               w_p[b] = idx[0] ? w_odd : ~w_odd;
            end
         end
      endcase
      return w_p;
   endfunction

   logic [2:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_idx;
   logic [2:0]            r_drain_cnt;
   logic [1:0]            r_mode;
   logic [DATA_WIDTH-1:0] r_seed;
   logic                  r_pv [RD_LATENCY];
   logic [ADDR_WIDTH-1:0] r_pa [RD_LATENCY];
   logic [DATA_WIDTH-1:0] r_pe [RD_LATENCY];

   logic [2:0]            w_state_nxt;
   logic [ADDR_WIDTH-1:0] w_idx_nxt;
   logic [1:0]            w_mode_nxt;
   logic [DATA_WIDTH-1:0] w_seed_nxt;
   logic                  w_push;
   logic                  w_accept;
   logic                  w_mis;
   logic                  w_stop;
   logic [ADDR_WIDTH:0]   w_err_cnt_nxt;
   logic [ADDR_WIDTH-1:0] w_err_addr_nxt;
   logic [DATA_WIDTH-1:0] w_err_exp_nxt;
   logic [DATA_WIDTH-1:0] w_err_act_nxt;

   // Compare at the last pipeline stage, where the RAM data for that entry is valid.
   always_comb begin
      w_mis  = r_pv[RD_LATENCY-1] && (mem_data_i != r_pe[RD_LATENCY-1]);
      w_stop = STOP_EN && w_mis;
   end

   // Sweep FSM next-state and address counter.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_push      = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_accept    = 1'b1;
               w_state_nxt = S_WRITE;
               w_idx_nxt   = '0;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_WRITE: begin
            if (r_idx == LAST_IDX) begin
               w_state_nxt = S_READ;
               w_idx_nxt   = '0;
            end else begin
               w_idx_nxt = r_idx + ADDR_WIDTH'(1);
            end
         end
         S_READ: begin
            if (w_stop) begin
               w_state_nxt = S_DONE;
               w_idx_nxt   = '0;
            end else begin
               w_push = 1'b1;
               if (r_idx == LAST_IDX) begin
                  w_state_nxt = S_DRAIN;
                  w_idx_nxt   = '0;
               end else begin
                  w_idx_nxt = r_idx + ADDR_WIDTH'(1);
               end
            end
         end
         S_DRAIN: begin
            if (w_stop || (r_drain_cnt == LAT_LAST)) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Configuration and error-record next values (cleared on an accepted start).
   always_comb begin
      w_mode_nxt     = r_mode;
      w_seed_nxt     = r_seed;
      w_err_cnt_nxt  = err_cnt_o;
      w_err_addr_nxt = err_addr_o;
      w_err_exp_nxt  = err_exp_o;
      w_err_act_nxt  = err_act_o;
      if (w_accept) begin
         w_mode_nxt     = mode_i;
         w_seed_nxt     = seed_i;
         w_err_cnt_nxt  = '0;
         w_err_addr_nxt = '0;
         w_err_exp_nxt  = '0;
         w_err_act_nxt  = '0;
      end else if (w_mis) begin
         if (err_cnt_o != CNT_MAX) begin
            w_err_cnt_nxt = err_cnt_o + (ADDR_WIDTH+1)'(1);
         end else begin
            w_err_cnt_nxt = err_cnt_o;
         end
         // Only the first mismatch of a run is recorded.
         if (err_cnt_o == '0) begin
            w_err_addr_nxt = r_pa[RD_LATENCY-1];
            w_err_exp_nxt  = r_pe[RD_LATENCY-1];
            w_err_act_nxt  = mem_data_i;
         end else begin
            w_err_addr_nxt = err_addr_o;
         end
      end else begin
         w_err_cnt_nxt = err_cnt_o;
      end
   end

   // Control state, configuration and registered outputs.
   always_ff @(posedge sys_clk_i or posedge sys_arst_i) begin
      if (sys_arst_i) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_drain_cnt <= 3'd0;
         r_mode      <= 2'd0;
         r_seed      <= '0;
         mem_addr_o  <= '0;
         mem_data_o  <= '0;
         mem_wen_o   <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         pass_o      <= 1'b0;
         err_cnt_o   <= '0;
         err_addr_o  <= '0;
         err_exp_o   <= '0;
         err_act_o   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_drain_cnt <= ((r_state == S_DRAIN) && (w_state_nxt == S_DRAIN)) ?
                        (r_drain_cnt + 3'd1) : 3'd0;
         r_mode      <= w_mode_nxt;
         r_seed      <= w_seed_nxt;
         // RAM port is driven from next-state values so it lines up with the FSM state.
         mem_wen_o   <= (w_state_nxt == S_WRITE);
         mem_addr_o  <= ((w_state_nxt == S_WRITE) || (w_state_nxt == S_READ)) ? w_idx_nxt : '0;
         mem_data_o  <= (w_state_nxt == S_WRITE) ?
                        f_pattern(w_mode_nxt, w_seed_nxt, w_idx_nxt) : '0;
         busy_o      <= (w_state_nxt != S_IDLE);
         done_o      <= (w_state_nxt == S_DONE);
         if (w_accept) begin
            pass_o <= 1'b0;
         end else if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
            pass_o <= (w_err_cnt_nxt == '0);
         end else begin
            pass_o <= pass_o;
         end
         err_cnt_o   <= w_err_cnt_nxt;
         err_addr_o  <= w_err_addr_nxt;
         err_exp_o   <= w_err_exp_nxt;
         err_act_o   <= w_err_act_nxt;
      end
   end

   // Compare pipeline: one {valid, addr, expected} entry per read issue.
   always_ff @(posedge sys_clk_i or posedge sys_arst_i) begin
      if (sys_arst_i) begin
         for (int k = 0; k < RD_LATENCY; k++) begin
            r_pv[k] <= 1'b0;
            r_pa[k] <= '0;
            r_pe[k] <= '0;
         end
      end else if (w_stop) begin
         for (int k = 0; k < RD_LATENCY; k++) begin
            r_pv[k] <= 1'b0;
            r_pa[k] <= '0;
            r_pe[k] <= '0;
         end
      end else begin
         r_pv[0] <= w_push;
         r_pa[0] <= r_idx;
         r_pe[0] <= f_pattern(r_mode, r_seed, r_idx);
         for (int k = 1; k < RD_LATENCY; k++) begin
            r_pv[k] <= r_pv[k-1];
            r_pa[k] <= r_pa[k-1];
            r_pe[k] <= r_pe[k-1];
         end
      end
   end

endmodule

// File: tb/tb_vgachargen_mem_bist.sv
// ----------------------------------------------------------------------------
// tb_vgachargen_mem_bist
// Two instances (read latency 1 and 3, DEPTH 2400) each driving a behavioural
// RAM with an optional read-side fault: one address ORed with a mask, or the
// whole array reading all-ones. Table-driven runs plus hand-written sequences
// for held start, re-arm and asynchronous reset in the middle of a read sweep.
// ----------------------------------------------------------------------------
module tb_vgachargen_mem_bist;

   localparam int D = 2400;
`ifdef VGACHARGEN_BIST_STOP_ON_ERR_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start1 = 1'b0;
   logic start3 = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [7:0] seed = 8'd0;
   logic sel = 1'b0;

   // read-side fault configuration shared by both RAM models
   logic [7:0]  f_or   = 8'd0;
   logic [11:0] f_addr = 12'd0;
   logic        f_all  = 1'b0;

   logic [11:0] addr1, addr3, eaddr1, eaddr3;
   logic [7:0]  wd1, wd3, rd1, eexp1, eexp3, eact1, eact3;
   logic        wen1, wen3, busy1, busy3, done1, done3, pass1, pass3;
   logic [12:0] cnt1, cnt3;
   logic [7:0]  mem1 [4096];
   logic [7:0]  mem3 [4096];
   logic [7:0]  rp3 [3];

   always #5 clk = ~clk;

   vgachargen_mem_bist #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .DEPTH(D), .RD_LATENCY(1)) u_dut1 (
      .sys_clk_i(clk), .sys_arst_i(rst), .start_i(start1), .mode_i(mode), .seed_i(seed),
      .mem_addr_o(addr1), .mem_data_o(wd1), .mem_wen_o(wen1), .mem_data_i(rd1),
      .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_cnt_o(cnt1),
      .err_addr_o(eaddr1), .err_exp_o(eexp1), .err_act_o(eact1));

   vgachargen_mem_bist #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .DEPTH(D), .RD_LATENCY(3)) u_dut3 (
      .sys_clk_i(clk), .sys_arst_i(rst), .start_i(start3), .mode_i(mode), .seed_i(seed),
      .mem_addr_o(addr3), .mem_data_o(wd3), .mem_wen_o(wen3), .mem_data_i(rp3[2]),
      .busy_o(busy3), .done_o(done3), .pass_o(pass3), .err_cnt_o(cnt3),
      .err_addr_o(eaddr3), .err_exp_o(eexp3), .err_act_o(eact3));

   function automatic logic [7:0] fault(input logic [11:0] a, input logic [7:0] d);
      logic [7:0] r;
      r = d;
      if (f_all) r = 8'hFF;
      if (a == f_addr) r = r | f_or;
      return r;
   endfunction

   // RAM with 1-cycle read latency
   always @(posedge clk) begin
      if (wen1) mem1[addr1] <= wd1;
      rd1 <= fault(addr1, mem1[addr1]);
   end

   // RAM with 3-cycle read latency
   always @(posedge clk) begin
      if (wen3) mem3[addr3] <= wd3;
      rp3[0] <= fault(addr3, mem3[addr3]);
      rp3[1] <= rp3[0];
      rp3[2] <= rp3[1];
   end

   logic        busy_s, done_s, pass_s;
   logic [12:0] cnt_s;
   logic [11:0] eaddr_s, maddr_s;
   logic [7:0]  eexp_s, eact_s;
   assign busy_s  = sel ? busy3  : busy1;
   assign done_s  = sel ? done3  : done1;
   assign pass_s  = sel ? pass3  : pass1;
   assign cnt_s   = sel ? cnt3   : cnt1;
   assign eaddr_s = sel ? eaddr3 : eaddr1;
   assign eexp_s  = sel ? eexp3  : eexp1;
   assign eact_s  = sel ? eact3  : eact1;
   assign maddr_s = sel ? addr3  : addr1;

   int tests = 0;
   int failed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          sel;
      logic [1:0]  mode;
      logic [7:0]  seed;
      logic [7:0]  f_or;
      logic [11:0] f_addr;
      bit          f_all;
      bit          e_pass;
      logic [12:0] e_cnt;
      logic [11:0] e_addr;
      logic [7:0]  e_exp;
      logic [7:0]  e_act;
      int          e_cyc;   // cycles from WRITE entry to the done_o cycle
      logic [11:0] c_addr;  // RAM word to inspect afterwards
      logic [7:0]  c_data;
   } vec_t;

   vec_t vecs[6];

   // Wait for done_o with a cycle bound; returns cycles since WRITE entry.
   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done_s && cyc < 6000) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic run_vec(input int n);
      vec_t v;
      int   cyc;
      v = vecs[n];
      @(negedge clk);
      sel = v.sel; f_or = v.f_or; f_addr = v.f_addr; f_all = v.f_all;
      mode = v.mode; seed = v.seed;
      if (v.sel) start3 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; start3 = 1'b0;
      chk($sformatf("v%0d busy_at_write", n), busy_s, 1);
      wait_done(cyc);
      chk($sformatf("v%0d done_cycle", n), cyc, v.e_cyc);
      chk($sformatf("v%0d pass", n), pass_s, v.e_pass);
      chk($sformatf("v%0d err_cnt", n), cnt_s, v.e_cnt);
      chk($sformatf("v%0d err_addr", n), eaddr_s, v.e_addr);
      chk($sformatf("v%0d err_exp", n), eexp_s, v.e_exp);
      chk($sformatf("v%0d err_act", n), eact_s, v.e_act);
      chk($sformatf("v%0d ram_word", n), v.sel ? mem3[v.c_addr] : mem1[v.c_addr], v.c_data);
      @(negedge clk);
      chk($sformatf("v%0d done_pulse", n), done_s, 0);
      chk($sformatf("v%0d pass_held", n), pass_s, v.e_pass);
      chk($sformatf("v%0d idle_busy_addr", n), {busy_s, maddr_s}, 13'd0);
   endtask

   initial begin
      int cyc;
      // sel mode seed or addr all pass cnt addr exp act cyc chk_addr chk_data
      vecs[0] = '{1'b0, 2'd0, 8'h00, 8'h00, 12'd0, 1'b0, 1'b1, 13'd0, 12'd0, 8'h00, 8'h00,
                  2*D+1, 12'd2399, 8'h5F};
      vecs[1] = '{1'b1, 2'd1, 8'h10, 8'h00, 12'd0, 1'b0, 1'b1, 13'd0, 12'd0, 8'h00, 8'h00,
                  2*D+3, 12'd0, 8'hEF};
      // bit 1 stuck at 1 on addr 5, ADDR pattern: 0x05 reads back as 0x07
      vecs[2] = '{1'b0, 2'd2, 8'h00, 8'h02, 12'd5, 1'b0, 1'b0, 13'd1, 12'd5, 8'h05, 8'h07,
                  STOP ? D+5+2 : 2*D+1, 12'd5, 8'h05};
      // bit 0 stuck at 1 on addr 5: 0x05 already has bit 0 set, so nothing to detect
      vecs[3] = '{1'b0, 2'd2, 8'h00, 8'h01, 12'd5, 1'b0, 1'b1, 13'd0, 12'd0, 8'h00, 8'h00,
                  2*D+1, 12'd4, 8'h04};
      // all-ones RAM, CHECKER: every word mismatches, first at addr 0 (0x55)
      vecs[4] = '{1'b0, 2'd3, 8'h00, 8'h00, 12'd0, 1'b1, 1'b0, STOP ? 13'd1 : 13'd2400,
                  12'd0, 8'h55, 8'hFF, STOP ? D+2 : 2*D+1, 12'd1, 8'hAA};
      // last address faulty, latency 3: 0xAA reads back as 0xAB
      vecs[5] = '{1'b1, 2'd3, 8'h00, 8'h01, 12'd2399, 1'b0, 1'b0, 13'd1, 12'd2399, 8'hAA,
                  8'hAB, 2*D+3, 12'd2398, 8'h55};

      // reset state
      repeat (2) @(negedge clk);
      chk("reset_status", {busy1, done1, pass1, busy3, done3, pass3}, 6'd0);
      chk("reset_mem_port", {wen1, addr1, wd1, wen3, addr3, wd3}, 42'd0);
      chk("reset_err", {cnt1, eaddr1, eexp1, eact1}, 41'd0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) run_vec(i);

      // start held high the whole run: ignored while busy, re-arms after DONE
      @(negedge clk);
      sel = 1'b0; f_or = 8'h00; f_all = 1'b0; mode = 2'd0; seed = 8'h00;
      start1 = 1'b1;
      @(negedge clk);
      chk("held_busy", busy1, 1);
      wait_done(cyc);
      chk("held_done_cycle", cyc, 2*D+1);
      @(negedge clk);
      chk("held_idle_gap", {busy1, done1}, 2'd0);
      @(negedge clk);
      chk("held_rearm", busy1, 1);
      start1 = 1'b0;

      // asynchronous reset in the middle of the read sweep, start pulses ignored
      repeat (2000) @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (997) @(negedge clk);
      chk("midread_busy", busy1, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_status", {busy1, done1, pass1, wen1}, 4'd0);
      chk("arst_mem_port", {addr1, wd1}, 20'd0);
      chk("arst_err", {cnt1, eaddr1, eexp1, eact1}, 41'd0);
      @(negedge clk);
      rst = 1'b0;
      run_vec(0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
